// File: rtl/cache_line_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller, 32-bit CPU port, 512-bit line bus.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_line_ctrl #(
    parameter int LINES = 16,
    parameter int AW    = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cpu_valid,
    input  logic           cpu_rw,
    input  logic [AW-1:0]  cpu_addr,
    input  logic [31:0]    cpu_wdata,
    output logic [31:0]    cpu_rdata,
    output logic           cpu_ready,
    output logic [AW-1:0]  mem_addr,
    output logic           mem_valid,
    output logic           mem_rw,
    output logic [511:0]   mem_wr_data,
    input  logic [511:0]   mem_rd_data,
    input  logic           mem_ready,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count
);

    localparam int IW = $clog2(LINES);
    localparam int TW = AW - 6 - IW;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        RESPOND
    } state_t;

    state_t            state_q;

    logic              req_rw_q;
    logic [IW-1:0]     req_idx_q;
    logic [TW-1:0]     req_tag_q;
    logic [3:0]        req_word_q;
    logic [31:0]       req_wdata_q;

    logic [511:0]      line_q [LINES];
    logic [TW-1:0]     tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;

    logic [31:0]       cpu_rdata_q;
    logic              cpu_ready_q;
    logic [AW-1:0]     mem_addr_q;
    logic              mem_valid_q;
    logic              mem_rw_q;
    logic [511:0]      mem_wr_data_q;

    logic              hit;
    logic              line_we;
    logic [511:0]      line_d;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    assign hit = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);

    // Store hits and fills share one array write port; stores merge their word.
    always_comb begin
        line_we = 1'b0;
        line_d  = line_q[req_idx_q];
        if (state_q == LOOKUP && hit && req_rw_q) begin
            line_we = 1'b1;
            line_d[{req_word_q, 5'b0} +: 32] = req_wdata_q;
        end else if (state_q == FILL_WAIT && mem_ready) begin
            line_we = 1'b1;
            line_d  = mem_rd_data;
            if (req_rw_q) begin
                line_d[{req_word_q, 5'b0} +: 32] = req_wdata_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[req_idx_q] <= line_d;
            tag_q[req_idx_q]  <= req_tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            dirty_q       <= '0;
            req_rw_q      <= 1'b0;
            req_idx_q     <= '0;
            req_tag_q     <= '0;
            req_word_q    <= '0;
            req_wdata_q   <= '0;
            cpu_rdata_q   <= '0;
            cpu_ready_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_valid_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_wr_data_q <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            mem_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_valid) begin
                        req_rw_q    <= cpu_rw;
                        req_idx_q   <= cpu_addr[6+IW-1:6];
                        req_tag_q   <= cpu_addr[AW-1:6+IW];
                        req_word_q  <= cpu_addr[5:2];
                        req_wdata_q <= cpu_wdata;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (req_rw_q) begin
                            dirty_q[req_idx_q] <= 1'b1;
                        end
                        state_q <= RESPOND;
                    end else if (valid_q[req_idx_q] && dirty_q[req_idx_q]) begin
                        state_q <= WB_REQ;
                    end else begin
                        state_q <= FILL_REQ;
                    end
                end
                WB_REQ: begin
                    mem_valid_q   <= 1'b1;
                    mem_rw_q      <= 1'b1;
                    mem_addr_q    <= {tag_q[req_idx_q], req_idx_q, 6'b0};
                    mem_wr_data_q <= line_q[req_idx_q];
                    state_q       <= WB_WAIT;
                end
                WB_WAIT: begin
                    if (mem_ready) begin
                        state_q <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    mem_valid_q <= 1'b1;
                    mem_rw_q    <= 1'b0;
                    mem_addr_q  <= {req_tag_q, req_idx_q, 6'b0};
                    state_q     <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (mem_ready) begin
                        valid_q[req_idx_q] <= 1'b1;
                        dirty_q[req_idx_q] <= req_rw_q;
                        state_q            <= RESPOND;
                    end
                end
                RESPOND: begin
                    cpu_ready_q <= 1'b1;
                    cpu_rdata_q <= line_q[req_idx_q][{req_word_q, 5'b0} +: 32];
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ready   = cpu_ready_q;
    assign mem_addr    = mem_addr_q;
    assign mem_valid   = mem_valid_q;
    assign mem_rw      = mem_rw_q;
    assign mem_wr_data = mem_wr_data_q;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) begin
                hit_q <= hit_q + 32'd1;
            end else begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl: misses, hits, write-back, store-allocate,
// reset during fill and cpu_valid toggling, against hand-computed values.
module tb_cache_line_ctrl;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cpu_valid = 1'b0;
    logic         cpu_rw = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic [31:0]  mem_addr;
    logic         mem_valid;
    logic         mem_rw;
    logic [511:0] mem_wr_data;
    logic [511:0] mem_rd_data = '0;
    logic         mem_ready = 1'b0;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    cache_line_ctrl #(.LINES(16), .AW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_valid   (cpu_valid),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .mem_addr    (mem_addr),
        .mem_valid   (mem_valid),
        .mem_rw      (mem_rw),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_ready   (mem_ready),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit [511:0] mem [bit [31:0]];

    int           lat;
    int           n_wb;
    int           n_fill;
    int           n_ready;
    int           n_stray;
    bit           got_ready;
    logic [31:0]  rdata;
    logic [31:0]  wb_addr;
    logic [31:0]  fill_addr;
    logic [511:0] wb_data;

    function automatic logic [511:0] line_pat(input logic [31:0] base);
        logic [511:0] l;
        for (int w = 0; w < 16; w++) begin
            l[32*w +: 32] = base + w;
        end
        return l;
    endfunction

    function automatic logic [31:0] cnt(input int n);
        return STATS ? n : 0;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic rw, input logic [31:0] a,
                          input logic [31:0] wd, input bit toggle);
        bit          pend;
        bit          rdy_hi;
        logic [31:0] paddr;
        pend = 0;
        rdy_hi = 0;
        paddr = '0;
        lat = 0;
        n_wb = 0;
        n_fill = 0;
        n_ready = 0;
        got_ready = 0;
        rdata = 'x;
        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_rw = rw;
        cpu_addr = a;
        cpu_wdata = wd;
        for (int c = 1; c <= 60 && !got_ready; c++) begin
            @(negedge clk);
            cpu_valid = toggle ? ~cpu_valid : 1'b0;
            if (rdy_hi) begin
                mem_ready = 1'b0;
                rdy_hi = 0;
            end
            if (pend) begin
                mem_ready = 1'b1;
                mem_rd_data = mem.exists(paddr) ? mem[paddr] : '0;
                pend = 0;
                rdy_hi = 1;
            end
            if (mem_valid) begin
                paddr = mem_addr;
                pend = 1;
                if (mem_rw) begin
                    n_wb++;
                    wb_addr = mem_addr;
                    wb_data = mem_wr_data;
                    mem[mem_addr] = mem_wr_data;
                end else begin
                    n_fill++;
                    fill_addr = mem_addr;
                end
            end
            if (cpu_ready) begin
                got_ready = 1;
                n_ready++;
                lat = c;
                rdata = cpu_rdata;
                cpu_valid = 1'b0;
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (rdy_hi) begin
                mem_ready = 1'b0;
                rdy_hi = 0;
            end
            if (cpu_ready) n_ready++;
        end
        chk("ready_seen", got_ready, 1'b1);
    endtask

    initial begin
        int stray;
        bit seen;
        mem[32'h040] = line_pat(32'h1111_2222);
        mem[32'h440] = line_pat(32'hA0A0_0000);
        mem[32'h080] = line_pat(32'h5555_0000);
        mem[32'h480] = line_pat(32'h7777_0000);
        mem[32'h0C0] = line_pat(32'h3333_0000);
        mem[32'h100] = line_pat(32'h0100_0000);

        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", cpu_ready, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_wr_data", mem_wr_data, 512'h0);
        chk("rst_hit_count", hit_count, 32'h0);
        chk("rst_miss_count", miss_count, 32'h0);
        rst = 1'b1;

        access(1'b0, 32'h0000_0040, 32'h0, 1'b0);
        chk("cold_rdata", rdata, 32'h1111_2222);
        chk("cold_fills", n_fill, 1);
        chk("cold_wbs", n_wb, 0);
        chk("cold_fill_addr", fill_addr, 32'h40);
        chk("cold_lat", lat, 6);
        chk("cold_miss_count", miss_count, cnt(1));

        access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
        chk("st_hit_rdata", rdata, 32'hDEAD_BEEF);
        chk("st_hit_mem", n_fill + n_wb, 0);
        chk("st_hit_lat", lat, 3);
        chk("st_hit_count", hit_count, cnt(1));

        access(1'b0, 32'h0000_0044, 32'h0, 1'b0);
        chk("ld_hit_rdata", rdata, 32'hDEAD_BEEF);
        chk("ld_hit_mem", n_fill + n_wb, 0);
        chk("ld_hit_lat", lat, 3);
        chk("ld_hit_count", hit_count, cnt(2));

        access(1'b0, 32'h0000_0440, 32'h0, 1'b0);
        chk("evict_wbs", n_wb, 1);
        chk("evict_wb_addr", wb_addr, 32'h40);
        chk("evict_wb_w1", wb_data[63:32], 32'hDEAD_BEEF);
        chk("evict_wb_w0", wb_data[31:0], 32'h1111_2222);
        chk("evict_fills", n_fill, 1);
        chk("evict_fill_addr", fill_addr, 32'h440);
        chk("evict_rdata", rdata, 32'hA0A0_0000);
        chk("evict_lat", lat, 9);
        chk("evict_miss_count", miss_count, cnt(2));

        access(1'b1, 32'h0000_0088, 32'hCAFE_F00D, 1'b0);
        chk("stmiss_fills", n_fill, 1);
        chk("stmiss_wbs", n_wb, 0);
        chk("stmiss_fill_addr", fill_addr, 32'h80);
        chk("stmiss_rdata", rdata, 32'hCAFE_F00D);
        chk("stmiss_lat", lat, 6);

        access(1'b0, 32'h0000_0084, 32'h0, 1'b0);
        chk("stmiss_nbr_rdata", rdata, 32'h5555_0001);
        chk("stmiss_nbr_mem", n_fill + n_wb, 0);

        access(1'b0, 32'h0000_048C, 32'h0, 1'b0);
        chk("evict2_wb_addr", wb_addr, 32'h80);
        chk("evict2_wb_w2", wb_data[95:64], 32'hCAFE_F00D);
        chk("evict2_wb_w1", wb_data[63:32], 32'h5555_0001);
        chk("evict2_rdata", rdata, 32'h7777_0003);
        chk("evict2_counts", {hit_count, miss_count}, {cnt(3), cnt(4)});

        @(negedge clk);
        cpu_valid = 1'b1;
        cpu_rw = 1'b0;
        cpu_addr = 32'h0000_00C0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            cpu_valid = 1'b0;
            if (mem_valid) seen = 1;
        end
        chk("rstmid_fill_req", seen, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_cpu_ready", cpu_ready, 1'b0);
        chk("rstmid_mem_valid", mem_valid, 1'b0);
        chk("rstmid_mem_addr", mem_addr, 32'h0);
        chk("rstmid_mem_rw", mem_rw, 1'b0);
        chk("rstmid_wr_data", mem_wr_data, 512'h0);
        chk("rstmid_rdata", cpu_rdata, 32'h0);
        chk("rstmid_counts", {hit_count, miss_count}, 64'h0);
        rst = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rd_data = mem[32'h0C0];
        @(negedge clk);
        mem_ready = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (cpu_ready || mem_valid) stray++;
        end
        chk("late_ready_ignored", stray, 0);

        access(1'b0, 32'h0000_0040, 32'h0, 1'b0);
        chk("reload_fills", n_fill, 1);
        chk("reload_wbs", n_wb, 0);
        chk("reload_rdata", rdata, 32'h1111_2222);
        chk("reload_lat", lat, 6);
        access(1'b0, 32'h0000_0044, 32'h0, 1'b0);
        chk("reload_w1_rdata", rdata, 32'hDEAD_BEEF);
        chk("reload_w1_lat", lat, 3);
        chk("reload_counts", {hit_count, miss_count}, {cnt(1), cnt(1)});

        access(1'b0, 32'h0000_0104, 32'h0, 1'b1);
        chk("toggle_readies", n_ready, 1);
        chk("toggle_fills", n_fill, 1);
        chk("toggle_rdata", rdata, 32'h0100_0001);
        chk("toggle_lat", lat, 6);
        chk("toggle_miss_count", miss_count, cnt(2));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
